// File: rtl/pl_timer_pkg.sv
// Shared constants and helpers for the PL interrupt timer slice.
package pl_timer_pkg;

    localparam int unsigned DEF_COUNT_WID = 27;
    localparam int unsigned DEF_PULSE_LEN = 9;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    function automatic int unsigned stretch_wid(input int unsigned pulse_len);
        return $clog2(pulse_len + 1);
    endfunction

endpackage

// File: rtl/pl_timer_ch.sv
// One timer channel: counter, period register, one-shot done flag,
// trigger stretch and sticky interrupt-pending flag.
module pl_timer_ch
    import pl_timer_pkg::*;
#(
    parameter int unsigned COUNT_WID      = DEF_COUNT_WID,
    parameter int unsigned PULSE_LEN      = DEF_PULSE_LEN,
    parameter int unsigned DEFAULT_PERIOD = 100000000
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic                 oneshot,
    input  logic                 period_wr,
    input  logic [COUNT_WID-1:0] period_data,
    input  logic                 irq_ack,
    output logic                 trig_out,
    output logic                 irq_pend,
    output logic                 done,
    output logic [COUNT_WID-1:0] count
);

    localparam int unsigned SW = stretch_wid(PULSE_LEN);

    logic [COUNT_WID-1:0] period;
    logic [SW-1:0]        stretch;
    logic                 terminal;

    // >= rather than == so a period shrunk below the live count still fires
    always_comb begin
        terminal = en && !done && (count >= period);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count    <= '0;
            period   <= COUNT_WID'(DEFAULT_PERIOD);
            done     <= 1'b0;
            trig_out <= 1'b0;
            stretch  <= '0;
            irq_pend <= 1'b0;
        end else begin
            if (period_wr) begin
                period <= period_data;
            end

            if (!en) begin
                count <= '0;
                done  <= 1'b0;
            end else if (terminal) begin
                if (oneshot == MODE_ONESHOT) begin
                    done <= 1'b1;
                end else begin
                    count <= '0;
                end
            end else if (!done) begin
                count <= count + 1'b1;
            end

            // stretch holds the high cycles still owed after the current one
            if (terminal) begin
                trig_out <= 1'b1;
                stretch  <= SW'(PULSE_LEN - 1);
            end else if (stretch != '0) begin
                trig_out <= 1'b1;
                stretch  <= stretch - 1'b1;
            end else begin
                trig_out <= 1'b0;
            end

            if (terminal) begin
                irq_pend <= 1'b1;
            end else if (irq_ack) begin
                irq_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pl_irq_timer.sv
// Multi-channel programmable interval timer feeding the PL-to-PS interrupt lines.
module pl_irq_timer
    import pl_timer_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned COUNT_WID      = DEF_COUNT_WID,
    parameter int unsigned PULSE_LEN      = DEF_PULSE_LEN,
    parameter int unsigned DEFAULT_PERIOD = 100000000,
    parameter int unsigned CH_WID         = 1
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [NUM_CH-1:0]           en,
    input  logic [NUM_CH-1:0]           oneshot,
    input  logic                        period_wr,
    input  logic [CH_WID-1:0]           period_ch,
    input  logic [COUNT_WID-1:0]        period_data,
    input  logic [NUM_CH-1:0]           irq_ack,
    output logic [NUM_CH-1:0]           trig_out,
    output logic [NUM_CH-1:0]           irq_pend,
    output logic [NUM_CH-1:0]           done,
    output logic [NUM_CH*COUNT_WID-1:0] count
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // out-of-range channel indices match no channel and are dropped
        assign wr_sel[i] = period_wr && (32'(period_ch) == i);

        pl_timer_ch #(
            .COUNT_WID      (COUNT_WID),
            .PULSE_LEN      (PULSE_LEN),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .nrst        (nrst),
            .en          (en[i]),
            .oneshot     (oneshot[i]),
            .period_wr   (wr_sel[i]),
            .period_data (period_data),
            .irq_ack     (irq_ack[i]),
            .trig_out    (trig_out[i]),
            .irq_pend    (irq_pend[i]),
            .done        (done[i]),
            .count       (count[i*COUNT_WID +: COUNT_WID])
        );
    end

endmodule
